// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: 4-digit common-anode seven-segment scanner with blanking gaps and frame tick
module seg7_scan_ctrl #(
   parameter int SCAN_DIV  = 50000,
   parameter int BLANK_CYC = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       wr_en,
   input  logic [1:0] wr_addr,
   input  logic [3:0] wr_data,
   input  logic [3:0] blank_mask,
   output logic [6:0] digits,
   output logic [3:0] sel,
   output logic       frame_tick
);
   localparam int MX = (SCAN_DIV > BLANK_CYC) ? ((SCAN_DIV > 2) ? SCAN_DIV : 2)
                                              : ((BLANK_CYC > 2) ? BLANK_CYC : 2);
   localparam int CW = $clog2(MX);
   localparam logic [CW-1:0] SCAN_LAST  = CW'(SCAN_DIV - 1);
   localparam logic [CW-1:0] BLANK_LAST = CW'((BLANK_CYC == 0) ? 0 : BLANK_CYC - 1);
   localparam logic [6:0] SEG [16] = '{
      7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
      7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
      7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
      7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
   };

   typedef enum logic {BLANK, DRIVE} state_t;

   state_t          state, nstate;
   logic [1:0]      idx, nidx;
   logic [CW-1:0]   cnt, ncnt;
   logic [3:0]      regs [4];
   logic [3:0]      nval;
   logic            last, on;

   // next scan position; outputs are registered from it so they line up with the state
   always_comb begin
      last   = (state == DRIVE) ? (cnt == SCAN_LAST) : (BLANK_CYC == 0 || cnt == BLANK_LAST);
      nstate = last ? ((state == BLANK || BLANK_CYC == 0) ? DRIVE : BLANK) : state;
      nidx   = (last && state == DRIVE) ? idx + 2'd1 : idx;
      ncnt   = last ? '0 : cnt + 1'b1;
      nval   = (wr_en && wr_addr == nidx) ? wr_data : regs[nidx];
      on     = nstate == DRIVE && !blank_mask[nidx];
   end

   // digit register file; a write bypasses into the display path above so it is never lost
   always_ff @(posedge clk) begin
      if (rst) regs <= '{default: '0};
      else if (wr_en) regs[wr_addr] <= wr_data;
   end

   // scan state machine with registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= BLANK;
         idx        <= '0;
         cnt        <= '0;
         sel        <= 4'hf;
         digits     <= 7'h7f;
         frame_tick <= 1'b0;
      end else begin
         state      <= nstate;
         idx        <= nidx;
         cnt        <= ncnt;
         sel        <= on ? ~(4'b1 << nidx) : 4'hf;
         digits     <= on ? SEG[nval] : 7'h7f;
         frame_tick <= state == DRIVE && last && idx == 2'd3;
      end
   end
endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// tb_seg7_scan_ctrl: directed table-driven bench for two scanner configurations
module tb_seg7_scan_ctrl;
   localparam logic [6:0] OFF = 7'b1111111, S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100,
                          S3 = 7'b0110000, S5 = 7'b0010010, SA = 7'b0001000, SF = 7'b0001110;

   typedef struct {
      bit         b;
      int         c;
      logic [3:0] m;
      logic       we;
      logic [1:0] wa;
      logic [3:0] wd;
      logic [3:0] s;
      logic [6:0] d;
      logic       t;
   } vec_t;

   logic       clk = 0, rst_a, rst_b, wr_en;
   logic [1:0] wr_addr;
   logic [3:0] wr_data, blank_mask;
   logic [6:0] dig_a, dig_b;
   logic [3:0] sel_a, sel_b;
   logic       tick_a, tick_b;
   int         total = 0, bad = 0, c = 0;
   int         n1, n2, n3;
   vec_t       tv[$];

   seg7_scan_ctrl #(.SCAN_DIV(4), .BLANK_CYC(2)) dut_a (
      .clk(clk), .rst(rst_a), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .blank_mask(blank_mask), .digits(dig_a), .sel(sel_a), .frame_tick(tick_a));

   seg7_scan_ctrl #(.SCAN_DIV(3), .BLANK_CYC(0)) dut_b (
      .clk(clk), .rst(rst_b), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .blank_mask(blank_mask), .digits(dig_b), .sel(sel_b), .frame_tick(tick_b));

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string n, input logic [11:0] act, input logic [11:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got sel/dig/tick=%b_%b_%b exp=%b_%b_%b", n,
                  act[11:8], act[7:1], act[0], exp[11:8], exp[7:1], exp[0]);
      end
   endtask

   task automatic add(input bit b, input int cy, input logic [3:0] m, input logic we,
                      input logic [1:0] wa, input logic [3:0] wd, input logic [3:0] s,
                      input logic [6:0] d, input logic t);
      vec_t v;
      v = '{b, cy, m, we, wa, wd, s, d, t};
      tv.push_back(v);
   endtask

   task automatic run(input int lo, input int hi);
      vec_t v;
      for (int i = lo; i < hi; i++) begin
         v = tv[i];
         while (c < v.c) begin
            blank_mask = v.m;
            wr_en      = (c == v.c - 1) && v.we;
            wr_addr    = v.wa;
            wr_data    = v.wd;
            step();
            c++;
         end
         wr_en = 0;
         check($sformatf("%s_c%0d", v.b ? "b" : "a", v.c),
               v.b ? {sel_b, dig_b, tick_b} : {sel_a, dig_a, tick_a}, {v.s, v.d, v.t});
      end
   endtask

   initial begin
      add(0, 0, 0, 0, 0, 0, 4'hf, OFF, 0);
      add(0, 1, 0, 0, 0, 0, 4'hf, OFF, 0);
      add(0, 2, 0, 0, 0, 0, 4'he, S0, 0);
      add(0, 5, 0, 0, 0, 0, 4'he, S0, 0);
      add(0, 6, 0, 0, 0, 0, 4'hf, OFF, 0);
      add(0, 7, 0, 0, 0, 0, 4'hf, OFF, 0);
      add(0, 8, 0, 0, 0, 0, 4'hd, S0, 0);
      add(0, 9, 0, 1, 0, 1, 4'hd, S0, 0);
      add(0, 10, 0, 1, 1, 2, 4'hd, S2, 0);
      add(0, 11, 0, 1, 2, 3, 4'hd, S2, 0);
      add(0, 12, 0, 1, 3, 4'ha, 4'hf, OFF, 0);
      add(0, 14, 0, 0, 0, 0, 4'hb, S3, 0);
      add(0, 20, 0, 0, 0, 0, 4'h7, SA, 0);
      add(0, 23, 0, 0, 0, 0, 4'h7, SA, 0);
      add(0, 24, 0, 0, 0, 0, 4'hf, OFF, 1);
      add(0, 25, 0, 0, 0, 0, 4'hf, OFF, 0);
      add(0, 26, 0, 0, 0, 0, 4'he, S1, 0);
      add(0, 30, 0, 0, 0, 0, 4'hf, OFF, 0);
      add(0, 32, 0, 0, 0, 0, 4'hd, S2, 0);
      add(0, 38, 0, 0, 0, 0, 4'hb, S3, 0);
      add(0, 44, 0, 0, 0, 0, 4'h7, SA, 0);
      add(0, 47, 0, 0, 0, 0, 4'h7, SA, 0);
      add(0, 48, 0, 0, 0, 0, 4'hf, OFF, 1);
      add(0, 49, 0, 0, 0, 0, 4'hf, OFF, 0);
      add(0, 50, 4, 0, 0, 0, 4'he, S1, 0);
      add(0, 56, 4, 0, 0, 0, 4'hd, S2, 0);
      add(0, 62, 4, 0, 0, 0, 4'hf, OFF, 0);
      add(0, 65, 4, 0, 0, 0, 4'hf, OFF, 0);
      add(0, 66, 4, 0, 0, 0, 4'hf, OFF, 0);
      add(0, 68, 4, 0, 0, 0, 4'h7, SA, 0);
      add(0, 72, 4, 0, 0, 0, 4'hf, OFF, 1);
      add(0, 74, 0, 0, 0, 0, 4'he, S1, 0);
      add(0, 78, 0, 1, 1, 5, 4'hf, OFF, 0);
      add(0, 80, 0, 0, 0, 0, 4'hd, S5, 0);
      add(0, 81, 0, 0, 0, 0, 4'hd, S5, 0);
      add(0, 82, 0, 1, 1, 4'hf, 4'hd, SF, 0);
      add(0, 83, 0, 0, 0, 0, 4'hd, SF, 0);
      add(0, 87, 0, 0, 0, 0, 4'hb, S3, 0);
      n1 = tv.size();
      add(0, 0, 0, 0, 0, 0, 4'hf, OFF, 0);
      add(0, 1, 0, 0, 0, 0, 4'hf, OFF, 0);
      add(0, 2, 0, 0, 0, 0, 4'he, S0, 0);
      add(0, 8, 0, 0, 0, 0, 4'hd, S0, 0);
      add(0, 14, 0, 0, 0, 0, 4'hb, S0, 0);
      add(0, 20, 0, 0, 0, 0, 4'h7, S0, 0);
      add(0, 24, 0, 0, 0, 0, 4'hf, OFF, 1);
      n2 = tv.size();
      add(1, 0, 0, 0, 0, 0, 4'hf, OFF, 0);
      add(1, 1, 0, 1, 0, 1, 4'he, S1, 0);
      add(1, 3, 0, 0, 0, 0, 4'he, S1, 0);
      add(1, 4, 0, 1, 1, 2, 4'hd, S2, 0);
      add(1, 6, 0, 0, 0, 0, 4'hd, S2, 0);
      add(1, 7, 0, 0, 0, 0, 4'hb, S0, 0);
      add(1, 10, 0, 0, 0, 0, 4'h7, S0, 0);
      add(1, 12, 0, 0, 0, 0, 4'h7, S0, 0);
      add(1, 13, 0, 0, 0, 0, 4'he, S1, 1);
      add(1, 14, 0, 0, 0, 0, 4'he, S1, 0);
      add(1, 16, 0, 0, 0, 0, 4'hd, S2, 0);
      add(1, 24, 0, 0, 0, 0, 4'h7, S0, 0);
      add(1, 25, 0, 0, 0, 0, 4'he, S1, 1);
      n3 = tv.size();

      rst_a = 1; rst_b = 1; wr_en = 0; wr_addr = 0; wr_data = 0; blank_mask = 0;
      step();
      step();
      wr_en = 1; wr_addr = 0; wr_data = 8;
      step();
      wr_en = 0;
      check("reset_a", {sel_a, dig_a, tick_a}, {4'hf, OFF, 1'b0});
      check("reset_b", {sel_b, dig_b, tick_b}, {4'hf, OFF, 1'b0});
      rst_a = 0; c = 0;
      run(0, n1);

      rst_a = 1; wr_en = 1; wr_addr = 0; wr_data = 7;
      step();
      wr_en = 0;
      check("midreset_a", {sel_a, dig_a, tick_a}, {4'hf, OFF, 1'b0});
      check("held_reset_b", {sel_b, dig_b, tick_b}, {4'hf, OFF, 1'b0});
      rst_a = 0; c = 0;
      run(n1, n2);

      rst_b = 0; c = 0;
      run(n2, n3);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/seg7_scan_ctrl.md
Name: seg7_scan_ctrl

Overview:
- Time-multiplexing controller for the board's 4-digit common-anode seven-segment display, driving the top-level `digits[6:0]` and `sel[3:0]` pins.
- Holds four 4-bit hex digit registers, written through a simple write port by the rest of the design.
- Scans the digits round-robin, inserting a blanking gap between slots to suppress ghosting.
- Emits a one-cycle frame tick after each full scan.

Parameters:
- SCAN_DIV, 50000, clock cycles a digit is actively driven per slot; legal range 1 or more.
- BLANK_CYC, 16, clock cycles all digits are off between slots; 0 means no blanking state.

Ports:
- clk  input  1  system clock; the only clock.
- rst  input  1  synchronous, active-high reset.
- wr_en  input  1  write strobe for a digit register.
- wr_addr  input  2  digit index written when wr_en=1; 0 is the rightmost digit (sel[0]).
- wr_data  input  4  hex value 0x0-0xF.
- blank_mask  input  4  bit i=1 keeps digit i dark during its slot; sampled every cycle.
- digits  output  7  segments, active-low, bit order {g,f,e,d,c,b,a}.
- sel  output  4  digit anode enables, active-low, at most one bit low at a time.
- frame_tick  output  1  one-cycle pulse at the end of slot 3's DRIVE.

Behaviour:
- One clock, clk. Reset is synchronous and active-high on rst, sampled on the rising edge and overriding every other input.
- Reset values:
  - digit registers 0.
  - state BLANK, idx 0, counter 0.
  - sel=4'b1111, digits=7'b1111111, frame_tick=0.
- All outputs are registered. No combinational path runs from any input to any output.
- State machine BLANK:
  - Outputs sel=1111, digits=1111111.
  - Counter runs 0..BLANK_CYC-1, then the machine enters DRIVE and the counter clears.
  - If BLANK_CYC=0, BLANK is never entered: DRIVE goes directly to DRIVE with the next idx, and the reset exit goes straight to DRIVE idx 0.
- State machine DRIVE:
  - sel[idx]=0 unless blank_mask[idx]=1, in which case sel=1111.
  - digits=decode(reg[idx]), or 1111111 when masked.
  - Counter runs 0..SCAN_DIV-1. On the last count: idx <= idx+1 mod 4 (3 wraps to 0), next state BLANK.
  - frame_tick=1 for exactly the one cycle after the last DRIVE count of idx 3, aligned with the first BLANK cycle.
- Slot period is SCAN_DIV+BLANK_CYC cycles. Frame period is 4*(SCAN_DIV+BLANK_CYC) cycles.
- Counter width is clog2(max(SCAN_DIV,BLANK_CYC,2)). The counter never exceeds its terminal count.
- Decode table, active-low, {g..a}:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
- Writes:
  - A write lands in reg[wr_addr] at the clock edge.
  - If that digit is currently in DRIVE, digits shows the new value on the following cycle (one-cycle latency).
  - A write in the same cycle as a slot change is never lost.
- blank_mask changes take effect on the next cycle. They do not alter timing or idx sequence.
- Reset asserted mid-slot:
  - Outputs return to reset values on the next edge.
  - Scanning restarts from BLANK idx 0 after rst deasserts.
  - Writes during rst are ignored.

Test Plan:
- Reset with SCAN_DIV=4, BLANK_CYC=2, then release -> sel=1111, digits=1111111 for 2 cycles; then sel=1110 with digits=1000000 for 4 cycles; then 2 blank cycles; then sel=1101.
- Write 1,2,3,A to addresses 0..3 and run one frame -> slot patterns 1111001/1110, 0100100/1101, 0110000/1011, 0001000/0111; frame_tick pulses every 24 cycles, exactly one cycle wide.
- blank_mask=4'b0100 -> during slot 2, sel=1111 and digits=1111111; slot timing and frame_tick period unchanged at 24.
- BLANK_CYC=0, SCAN_DIV=3 -> sel sequence 1110,1101,1011,0111, each held 3 cycles with no blank gap; frame_tick period 12.
- Write F to address 1 during slot 1's DRIVE count 1 -> digits changes to 0001110 on the next cycle; a write coinciding with the last DRIVE cycle of slot 0 is shown in the following slot 1.
- Assert rst for 1 cycle mid-slot 2 -> outputs return to reset values on the next edge, digit registers read 0, and scanning resumes at idx 0 after the blank period.
